// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer and the pipeline
// registers it controls.
//   state_t       : sequencer state encoding (RUN, MEM_WAIT, ERROR)
//   MIPS_REG_W    : default register-specifier width
//   hazard_ctrl_t : bundle of the seven stall/flush/bubble controls
//   CTRL_*        : canned control words shared with the pipeline registers
package pipe_ctrl_pkg;

  localparam int MIPS_REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_write;
    logic mem_wb_bubble;
  } hazard_ctrl_t;

  // Every register frozen, nothing injected.
  localparam hazard_ctrl_t CTRL_FROZEN = '{
    pc_write:      1'b0,
    if_id_write:   1'b0,
    if_id_flush:   1'b0,
    id_ex_bubble:  1'b0,
    ex_mem_write:  1'b0,
    mem_wb_write:  1'b0,
    mem_wb_bubble: 1'b0
  };

  // Normal flow: every register advances, no NOPs injected.
  localparam hazard_ctrl_t CTRL_FLOW = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    if_id_flush:   1'b0,
    id_ex_bubble:  1'b0,
    ex_mem_write:  1'b1,
    mem_wb_write:  1'b1,
    mem_wb_bubble: 1'b0
  };

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-relevant pipeline fields and the stall/flush controls.
//   master : pipeline side, drives stage fields, receives controls
//   slave  : hazard sequencer, reads stage fields, drives controls
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = MIPS_REG_W,
  parameter int STALL_CNT_W = 16
);

  logic [REG_W-1:0]       id_rs;
  logic [REG_W-1:0]       id_rt;
  logic                   id_uses_rt;
  logic                   ex_mem_read;
  logic [REG_W-1:0]       ex_rt;
  logic                   id_redirect;
  logic                   mem_req;
  logic                   dmem_ready;

  logic                   pc_write;
  logic                   if_id_write;
  logic                   if_id_flush;
  logic                   id_ex_bubble;
  logic                   ex_mem_write;
  logic                   mem_wb_write;
  logic                   mem_wb_bubble;
  logic                   mem_err;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           id_redirect, mem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_mem_write, mem_wb_write, mem_wb_bubble,
           mem_err, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           id_redirect, mem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           ex_mem_write, mem_wb_write, mem_wb_bubble,
           mem_err, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
//   ex_mem_read : EX holds a load
//   ex_rt       : destination of that load
//   id_rs/id_rt : source fields of the instruction in ID
//   id_uses_rt  : ID actually reads rt
//   load_use    : ID needs the load result before it exists
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  // Loads into $0 are discarded by the register file, so they never
  // create a real dependency.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : hazard fields in, register enables / flush / bubble out,
//              sticky memory-timeout flag and saturating stall counter
// Priority: ERROR freeze > memory stall > load-use > redirect > flow.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = MIPS_REG_W,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int STALL_CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  state_t                 state;
  logic [TO_W-1:0]        wait_cnt;
  logic [TO_W-1:0]        wait_cnt_inc;
  logic                   mem_err;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   load_use;
  logic                   mem_stall;
  hazard_ctrl_t           ctrl;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .load_use    (load_use)
  );

  // mem_req only matters when a new access starts in RUN; once waiting,
  // only dmem_ready can release the stall.
  assign mem_stall = ((state == RUN) && bus.mem_req && !bus.dmem_ready) ||
                     ((state == MEM_WAIT) && !bus.dmem_ready);

  assign wait_cnt_inc = wait_cnt + TO_W'(1);

  // Control word selection. During a memory stall everything holds
  // except MEM/WB, which loads a bubble so WB does not commit the same
  // instruction twice. A redirect seen together with a load-use is
  // dropped; the branch resolves again next cycle.
  always_comb begin
    ctrl = CTRL_FLOW;
    if (rst || (state != RUN && state != MEM_WAIT)) begin
      ctrl = CTRL_FROZEN;
    end else if (mem_stall) begin
      ctrl               = CTRL_FROZEN;
      ctrl.mem_wb_write  = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end else if (bus.id_redirect) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  // Sequencer state, watchdog and stall statistics. wait_cnt holds the
  // number of stall cycles already spent on the current access, so the
  // error is raised on the edge that completes the MEM_TIMEOUT-th one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (bus.mem_req && !bus.dmem_ready) begin
            wait_cnt <= TO_W'(1);
            if (TIMEOUT_VAL == TO_W'(1)) begin
              state   <= ERROR;
              mem_err <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT_VAL) begin
              state   <= ERROR;
              mem_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.if_id_write   = ctrl.if_id_write;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
  assign bus.ex_mem_write  = ctrl.ex_mem_write;
  assign bus.mem_wb_write  = ctrl.mem_wb_write;
  assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign bus.mem_err       = mem_err;
  assign bus.stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// hazard rules. Control words are compared as 7-bit vectors ordered
// {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write,
//  mem_wb_write, mem_wb_bubble}.
module tb_pipe_hazard_ctrl;

  localparam int REG_W       = 5;
  localparam int TO_W        = 8;
  localparam int MEM_TIMEOUT = 4;
  localparam int STALL_CNT_W = 4;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

  localparam logic [6:0] C_FROZEN = 7'b0000000;
  localparam logic [6:0] C_MEMSTL = 7'b0000011;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;
  localparam logic [6:0] C_REDIR  = 7'b1110110;
  localparam logic [6:0] C_FLOW   = 7'b1100110;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(REG_W), .STALL_CNT_W(STALL_CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .REG_W       (REG_W),
    .TO_W        (TO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: whether an access is outstanding, how many stall
  // cycles it has consumed, whether the watchdog has fired, and the
  // running count of cycles in which the PC was held.
  bit m_waiting;
  bit m_dead;
  bit m_err;
  int m_waits;
  int m_stalls;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
            bus.ex_mem_write, bus.mem_wb_write, bus.mem_wb_bubble};
  endfunction

  function automatic void model_reset();
    m_waiting = 1'b0;
    m_dead    = 1'b0;
    m_err     = 1'b0;
    m_waits   = 0;
    m_stalls  = 0;
  endfunction

  function automatic logic [6:0] model_ctrl();
    bit stall;
    bit lu;
    if (rst || m_dead) return C_FROZEN;
    stall = m_waiting ? !bus.dmem_ready : (bus.mem_req && !bus.dmem_ready);
    if (stall) return C_MEMSTL;
    lu = bus.ex_mem_read && (bus.ex_rt != 0) &&
         ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    if (lu) return C_LDUSE;
    if (bus.id_redirect) return C_REDIR;
    return C_FLOW;
  endfunction

  function automatic void model_step(input bit pc_held);
    if (pc_held) m_stalls = (m_stalls < STALL_MAX) ? m_stalls + 1 : STALL_MAX;
    if (m_dead) return;
    if (m_waiting) begin
      if (bus.dmem_ready) begin
        m_waiting = 1'b0;
        m_waits   = 0;
      end else begin
        m_waits++;
      end
    end else if (bus.mem_req && !bus.dmem_ready) begin
      m_waiting = 1'b1;
      m_waits   = 1;
    end
    if (m_waiting && m_waits >= MEM_TIMEOUT) begin
      m_dead = 1'b1;
      m_err  = 1'b1;
    end
  endfunction

  // Drives one cycle's worth of inputs just after the falling edge, so the
  // values are stable well before the next rising edge.
  task automatic applyStimulus(input logic r, input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt, input logic uses_rt,
                               input logic mread, input logic [REG_W-1:0] ert,
                               input logic redir, input logic req,
                               input logic rdy);
    @(negedge clk);
    rst             = r;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rt  = uses_rt;
    bus.ex_mem_read = mread;
    bus.ex_rt       = ert;
    bus.id_redirect = redir;
    bus.mem_req     = req;
    bus.dmem_ready  = rdy;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  // Compares the DUT against the model mid-cycle, then advances the model
  // to what the coming rising edge should produce.
  task automatic stepCycle(input string tag);
    logic [6:0] exp;
    #1;
    if (rst) model_reset();
    exp = model_ctrl();
    checkOutput({tag, "_ctrl"}, 32'(ctrl_vec()), 32'(exp));
    checkOutput({tag, "_err"}, 32'(bus.mem_err), 32'(m_err));
    checkOutput({tag, "_stall"}, 32'(bus.stall_cycles), 32'(m_stalls));
    if (!rst) model_step(!exp[6]);
  endtask

  initial begin
    rst = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rt = '0; bus.id_redirect = 1'b0;
    bus.mem_req = 1'b0; bus.dmem_ready = 1'b0;
    model_reset();

    // Reset state
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    stepCycle("reset");
    checkOutput("reset_ctrl_zero", 32'(ctrl_vec()), 32'(C_FROZEN));
    checkOutput("reset_stall_zero", 32'(bus.stall_cycles), 32'd0);
    idle(1'b0);
    stepCycle("post_reset");
    checkOutput("post_reset_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Load-use on rs: one bubble cycle, stall counter 0 -> 1
    applyStimulus(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    stepCycle("lu");
    checkOutput("lu_bubble", 32'(ctrl_vec()), 32'(C_LDUSE));
    checkOutput("lu_stall_before", 32'(bus.stall_cycles), 32'd0);
    idle(1'b0);
    stepCycle("lu_after");
    checkOutput("lu_release", 32'(ctrl_vec()), 32'(C_FLOW));
    checkOutput("lu_stall_after", 32'(bus.stall_cycles), 32'd1);

    // Load into $0 never stalls
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    stepCycle("zero_reg");
    checkOutput("zero_reg_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Load-use on rt only counts when rt is read
    applyStimulus(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    stepCycle("lu_rt");
    checkOutput("lu_rt_bubble", 32'(ctrl_vec()), 32'(C_LDUSE));
    applyStimulus(1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    stepCycle("lu_rt_unused");
    checkOutput("lu_rt_unused_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Branch during load-use is ignored, then honoured next cycle
    applyStimulus(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    stepCycle("br_lu");
    checkOutput("br_lu_noflush", 32'(ctrl_vec()), 32'(C_LDUSE));
    applyStimulus(1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    stepCycle("br_retry");
    checkOutput("br_retry_flush", 32'(ctrl_vec()), 32'(C_REDIR));

    // Single-cycle access: request and ready together
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    stepCycle("mem_fast");
    checkOutput("mem_fast_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Three wait cycles, zero-cycle release on the fourth
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, i == 0, 1'b0);
      stepCycle("mem_wait");
      checkOutput("mem_wait_hold", 32'(ctrl_vec()), 32'(C_MEMSTL));
    end
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    stepCycle("mem_release");
    checkOutput("mem_release_flow", 32'(ctrl_vec()), 32'(C_FLOW));
    idle(1'b0);
    stepCycle("mem_back_run");
    checkOutput("mem_back_run_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Watchdog: four unanswered wait cycles trip ERROR
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      stepCycle("to_wait");
      checkOutput("to_err_low", 32'(bus.mem_err), 32'd0);
    end
    idle(1'b0);
    stepCycle("to_tripped");
    checkOutput("to_err_set", 32'(bus.mem_err), 32'd1);
    checkOutput("to_frozen", 32'(ctrl_vec()), 32'(C_FROZEN));
    applyStimulus(1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    stepCycle("to_ready_pulse");
    checkOutput("to_still_frozen", 32'(ctrl_vec()), 32'(C_FROZEN));
    for (int i = 0; i < 2 * STALL_MAX; i++) begin
      idle(1'b1);
      stepCycle("to_sat");
    end
    checkOutput("stall_saturated", 32'(bus.stall_cycles), 32'(STALL_MAX));
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    stepCycle("to_reset");
    checkOutput("to_reset_err", 32'(bus.mem_err), 32'd0);
    idle(1'b0);
    stepCycle("to_recovered");
    checkOutput("to_recovered_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Asynchronous reset between edges abandons an outstanding access
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      stepCycle("ar_wait");
    end
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    stepCycle("ar_assert");
    checkOutput("ar_stall_clear", 32'(bus.stall_cycles), 32'd0);
    idle(1'b0);
    stepCycle("ar_run");
    checkOutput("ar_run_flow", 32'(ctrl_vec()), 32'(C_FLOW));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                    1'($urandom), $urandom_range(0, 2) == 0,
                    REG_W'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      stepCycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
